// File: rtl/updown_counter_bank_if.sv
`default_nettype none
// ============================================================================
//  Module      : updown_counter_bank_if
//  Description : Control/status bundle for updown_counter_bank.
//                master drives clr/load/up/down/data and observes the
//                count and flag outputs; slave is the counter bank side.
//  Signals     : clr      - synchronous clear of all channels
//                load     - per-channel load strobe            [CH]
//                up       - per-channel increment request      [CH]
//                down     - per-channel decrement request      [CH]
//                data     - load values, channel i at [i*W +: W]
//                count    - counter values, channel i at [i*W +: W]
//                at_max   - count[i] == MAX                    [CH]
//                at_min   - count[i] == 0                      [CH]
//                wrap     - one-cycle wrap pulse               [CH]
//                any_wrap - OR of wrap
//  Revision    : 1.0 - initial release
// ============================================================================
interface updown_counter_bank_if #(
   parameter int W  = 8,
   parameter int CH = 4
) ();
   logic              clr;
   logic [CH-1:0]     load;
   logic [CH-1:0]     up;
   logic [CH-1:0]     down;
   logic [CH*W-1:0]   data;
   logic [CH*W-1:0]   count;
   logic [CH-1:0]     at_max;
   logic [CH-1:0]     at_min;
   logic [CH-1:0]     wrap;
   logic              any_wrap;

   modport master (
      output clr, load, up, down, data,
      input  count, at_max, at_min, wrap, any_wrap
   );

   modport slave (
      input  clr, load, up, down, data,
      output count, at_max, at_min, wrap, any_wrap
   );
endinterface
`default_nettype wire

// File: rtl/updown_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module      : updown_counter_bank
//  Description : CH independent W-bit up/down counters sharing a terminal
//                value MAX, with wrap (SAT=0) or saturate (SAT=1) behaviour.
//                Per-channel priority: clr > load > step. Loads are clamped
//                to MAX so a count never exceeds the terminal value.
//  Ports       : clk    - clock, rising edge active
//                arst_n - asynchronous active-low reset
//                bus    - updown_counter_bank_if.slave (control + status)
//  Revision    : 1.0 - initial release
// ============================================================================
module updown_counter_bank #(
   parameter int             W   = 8,
   parameter int             CH  = 4,
   parameter logic [W-1:0]   MAX = {W{1'b1}},
   parameter int             SAT = 0
) (
   input  logic                   clk,
   input  logic                   arst_n,
   updown_counter_bank_if.slave   bus
);

   localparam logic [W-1:0] c_ZERO = '0;
   localparam logic [W-1:0] c_ONE  = W'(1);

   logic [CH*W-1:0] count_vec;
   logic [CH-1:0]   at_max_vec;
   logic [CH-1:0]   at_min_vec;
   logic [CH-1:0]   wrap_vec;

   generate
      for (genvar gi = 0; gi < CH; gi++) begin : g_ch
         logic [W-1:0] count_q;
         logic [W-1:0] count_d;
         logic         wrap_q;
         logic         wrap_d;
         logic [W-1:0] data_w;
         logic         inc_w;
         logic         dec_w;

         assign data_w = bus.data[gi*W +: W];
         // up and down together cancel out and hold the count
         assign inc_w  = bus.up[gi] & ~bus.down[gi];
         assign dec_w  = bus.down[gi] & ~bus.up[gi];

         always_comb begin
            count_d = count_q;
            wrap_d  = 1'b0;
            if (bus.clr) begin
               count_d = c_ZERO;
            end else if (bus.load[gi]) begin
               count_d = (data_w > MAX) ? MAX : data_w;
            end else if (inc_w) begin
               if (count_q == MAX) begin
                  // saturate mode keeps MAX (the default above)
                  if (SAT == 0) begin
                     count_d = c_ZERO;
                     wrap_d  = 1'b1;
                  end
               end else begin
                  count_d = count_q + c_ONE;
               end
            end else if (dec_w) begin
               if (count_q == c_ZERO) begin
                  if (SAT == 0) begin
                     count_d = MAX;
                     wrap_d  = 1'b1;
                  end
               end else begin
                  count_d = count_q - c_ONE;
               end
            end
         end

         always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
               count_q <= c_ZERO;
               wrap_q  <= 1'b0;
            end else begin
               count_q <= count_d;
               wrap_q  <= wrap_d;
            end
         end

         assign count_vec[gi*W +: W] = count_q;
         assign at_max_vec[gi]       = (count_q == MAX);
         assign at_min_vec[gi]       = (count_q == c_ZERO);
         assign wrap_vec[gi]         = wrap_q;
      end
   endgenerate

   assign bus.count    = count_vec;
   assign bus.at_max   = at_max_vec;
   assign bus.at_min   = at_min_vec;
   assign bus.wrap     = wrap_vec;
   assign bus.any_wrap = |wrap_vec;

endmodule
`default_nettype wire

// File: doc/updown_counter_bank.md
# updown_counter_bank

Bank of `CH` independent, parametrised up/down counters with a programmable terminal value, selectable wrap or saturate mode, and per-channel terminal/wrap flags. Successor to the single-channel 8-bit up/down counter: adds channel replication, a modulus other than 2^W, defined simultaneous-command behaviour, load clamping and a global synchronous clear. Used as the shared event/timer counter resource for blocks that need several small counters with identical control semantics.

## Interface

Parameters:
- `W`, 8, counter width per channel; 2..32
- `CH`, 4, number of channels; 1..16
- `MAX`, 2**W-1, terminal value of every channel; 1 <= MAX <= 2**W-1
- `SAT`, 0, 0 = wrap mode, 1 = saturate mode

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `arst_n`  in  1  reset, asynchronous, active-low
- `clr`  in  1  synchronous clear of all channels
- `load`  in  CH  per-channel load strobe
- `up`  in  CH  per-channel increment request
- `down`  in  CH  per-channel decrement request
- `data`  in  CH*W  load values; channel i at bits [i*W +: W]
- `count`  out  CH*W  counter values; channel i at bits [i*W +: W]
- `at_max`  out  CH  combinational, count[i] == MAX
- `at_min`  out  CH  combinational, count[i] == 0
- `wrap`  out  CH  registered one-cycle pulse, channel i wrapped (wrap mode only)
- `any_wrap`  out  1  OR-reduction of `wrap`

## Operation

- Channels are fully independent; only `clr` is shared.
- Per-channel priority, evaluated each rising edge: `clr` > `load[i]` > step.
- `clr`: count[i] <= 0 for all i; wrap <= 0.
- `load[i]`: count[i] <= min(data[i], MAX); `up`/`down` ignored that cycle; wrap[i] <= 0.
- Step command: up=1,down=0 -> increment; up=0,down=1 -> decrement; up=down (both 0 or both 1) -> hold.
- Increment at count == MAX: wrap mode -> 0, wrap[i] <= 1; saturate mode -> stays MAX, wrap[i] <= 0.
- Decrement at count == 0: wrap mode -> MAX, wrap[i] <= 1; saturate mode -> stays 0, wrap[i] <= 0.
- All other cycles: wrap[i] <= 0 (pulse lasts exactly one cycle).
- Count never exceeds MAX under any input sequence.
- Arithmetic is unsigned W-bit; comparisons against MAX use W-bit values; no carry out of W bits is ever observed.

## Timing

- Reset (`arst_n` low): count = 0, wrap = 0, any_wrap = 0 immediately, independent of `clk`; at_min = all 1s, at_max = 0. Deassertion takes effect at the first rising edge after release; inputs sampled at that edge act normally.
- Reset asserted mid-sequence discards any pending load or step; no wrap pulse is generated.
- Latency: command sampled at edge N -> new count visible after edge N; wrap[i] asserted in the same cycle as the wrapped count value (after edge N), cleared after edge N+1 unless another wrap occurs.
- Back-to-back wraps (MAX=1, up held): wrap[i] stays high each cycle a wrap occurs.
- at_max / at_min follow count combinationally; no added latency.
- No handshakes; every input is sampled every cycle.

## Test plan

- Async reset: W=4,CH=2,MAX=9; count ch0=5, drop `arst_n` between edges -> count=0, wrap=0 before next edge; release with up[0]=1 -> ch0=1 after first edge.
- Wrap up: MAX=9,SAT=0, load ch0=8, up held -> 9 (at_max=1), then 0 with wrap[0]=1, any_wrap=1 for one cycle, then 1 with wrap[0]=0; ch1 unchanged.
- Wrap down: MAX=9,SAT=0, ch1=0, down[1]=1 -> ch1=9, wrap[1]=1 one cycle; next decrement -> 8, wrap[1]=0.
- Saturate: SAT=1,MAX=9, ch0=9 up held 3 cycles -> stays 9, wrap=0; ch0=0 down held -> stays 0, wrap=0.
- Priority/clamp: load[0]=1,data=12,up[0]=1 -> ch0=9; up[0]=down[0]=1 -> ch0 holds 9; clr=1 with load[1]=1,data=3 -> both channels 0.
- Channel independence: CH=4, each channel given different up/down/load pattern for 50 random cycles -> each count matches a per-channel reference model; no cross-channel effects.
